// File: rtl/paddle2quad.sv
// paddle2quad: converts an absolute 8-bit paddle position into relative quadrature steps
//   clk_sys  in   system clock
//   reset    in   synchronous active-high reset
//   enable   in   analog/paddle mode selected; 0 parks the block in IDLE
//   target   in   absolute position, 0x00 = full left
//   steer    out  quadrature {A,B}
//   dir      out  direction of last emitted step (1 = up/right)
//   busy     out  high while stepping towards target
module paddle2quad #(
   parameter int CLKDIV   = 5500,
   parameter int DEADBAND = 1
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] target,
   output logic [1:0] steer,
   output logic       dir,
   output logic       busy
);
   localparam int DW = $clog2(CLKDIV);
   typedef enum logic [1:0] {SYNC, IDLE, MOVE} state_t;
   state_t state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [7:0] target_q, pos_q, pos_d;
   logic [1:0] q_q, q_d, steer_q, steer_d;
   logic en_q, dir_q, dir_d, busy_q, busy_d, tick;
   assign steer = steer_q;
   assign dir   = dir_q;
   assign busy  = busy_q;
   assign tick  = div_q == DW'(CLKDIV - 1);
   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + 1'b1;
      pos_d   = pos_q;
      q_d     = q_q;
      dir_d   = dir_q;
      if (!enable) begin
         state_d = IDLE;
         div_d   = '0;
      end else if (!en_q) begin
         // a fresh enable re-aligns pos to target so a mode switch never bursts steps
         state_d = SYNC;
         div_d   = '0;
      end else begin
         case (state_q)
            SYNC: begin
               pos_d   = target_q;
               state_d = IDLE;
               div_d   = '0;
            end
            IDLE: state_d = ({1'b0, target_q} > {1'b0, pos_q} + 9'(DEADBAND) ||
                             {1'b0, pos_q} > {1'b0, target_q} + 9'(DEADBAND)) ? MOVE : IDLE;
            MOVE: if (tick) begin
               if (pos_q < target_q) begin
                  pos_d = pos_q + 8'd1;
                  q_d   = q_q + 2'd1;
                  dir_d = 1'b1;
               end else if (pos_q > target_q) begin
                  pos_d = pos_q - 8'd1;
                  q_d   = q_q - 2'd1;
                  dir_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = SYNC;
         endcase
      end
      // Gray code: q 0,1,2,3 -> 00,01,11,10
      steer_d = {q_d[1], q_d[1] ^ q_d[0]};
      busy_d  = state_d == MOVE;
   end
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q  <= SYNC;
         div_q    <= '0;
         target_q <= 8'h80;
         pos_q    <= 8'h80;
         q_q      <= 2'd0;
         en_q     <= 1'b0;
         dir_q    <= 1'b0;
         steer_q  <= 2'b00;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         target_q <= target;
         pos_q    <= pos_d;
         q_q      <= q_d;
         en_q     <= enable;
         dir_q    <= dir_d;
         steer_q  <= steer_d;
         busy_q   <= busy_d;
      end
   end
endmodule

// File: tb/tb_paddle2quad.sv
// tb_paddle2quad: directed self-checking bench for paddle2quad (CLKDIV=4, DEADBAND=1)
module tb_paddle2quad;
   logic clk_sys = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic [7:0] target = 8'h80;
   logic [1:0] steer;
   logic dir, busy;
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic [1:0] seq[$];
   int stamps[$];
   int busy_rises = 0;
   int busy_fall_cyc = 0;
   logic [1:0] prev_steer = 2'b00;
   logic prev_busy = 1'b0;

   paddle2quad #(.CLKDIV(4), .DEADBAND(1)) dut (
      .clk_sys(clk_sys), .reset(reset), .enable(enable), .target(target),
      .steer(steer), .dir(dir), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   // record every steer change and busy edge, settled 2ns after the clock
   always @(posedge clk_sys) begin
      #2;
      cyc++;
      if (steer !== prev_steer) begin
         seq.push_back(steer);
         stamps.push_back(cyc);
      end
      if (busy && !prev_busy) busy_rises++;
      if (!busy && prev_busy) busy_fall_cyc = cyc;
      prev_steer = steer;
      prev_busy  = busy;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic clear_log();
      seq.delete();
      stamps.delete();
      busy_rises = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycles(3);
      tests++; if (steer !== 2'b00) begin fails++; $display("FAIL reset_steer got %b want 00", steer); end
      tests++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir got %b want 0", dir); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (dut.pos_q !== 8'h80) begin fails++; $display("FAIL reset_pos got %h want 80", dut.pos_q); end
      reset = 1'b0;
      cycles(1);
   endtask

   task automatic test_sync();
      clear_log();
      target = 8'h80;
      enable = 1'b1;
      cycles(20);
      tests++; if (seq.size() !== 0) begin fails++; $display("FAIL sync_steps got %0d want 0", seq.size()); end
      tests++; if (busy_rises !== 0) begin fails++; $display("FAIL sync_busy got %0d rises want 0", busy_rises); end
      tests++; if (dut.pos_q !== 8'h80) begin fails++; $display("FAIL sync_pos got %h want 80", dut.pos_q); end
   endtask

   task automatic test_move_up();
      logic [1:0] exp [3] = '{2'b01, 2'b11, 2'b10};
      clear_log();
      target = 8'h83;
      cycles(3);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL up_busy_during got %b want 1", busy); end
      cycles(30);
      tests++; if (seq.size() !== 3) begin fails++; $display("FAIL up_count got %0d want 3", seq.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            tests++; if (seq[i] !== exp[i]) begin fails++; $display("FAIL up_step%0d got %b want %b", i, seq[i], exp[i]); end
         end
         tests++; if (stamps[1] - stamps[0] !== 4 || stamps[2] - stamps[1] !== 4) begin
            fails++; $display("FAIL up_spacing got %0d,%0d want 4,4", stamps[1] - stamps[0], stamps[2] - stamps[1]);
         end
         tests++; if (busy_fall_cyc - stamps[2] !== 4) begin fails++; $display("FAIL up_busy_fall got %0d want 4", busy_fall_cyc - stamps[2]); end
      end
      tests++; if (dir !== 1'b1) begin fails++; $display("FAIL up_dir got %b want 1", dir); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL up_busy_end got %b want 0", busy); end
      tests++; if (dut.pos_q !== 8'h83) begin fails++; $display("FAIL up_pos got %h want 83", dut.pos_q); end
   endtask

   task automatic test_move_down_deadband();
      clear_log();
      target = 8'h81;
      cycles(30);
      tests++; if (seq.size() !== 2) begin fails++; $display("FAIL down_count got %0d want 2", seq.size()); end
      else begin
         tests++; if (seq[0] !== 2'b11 || seq[1] !== 2'b01) begin fails++; $display("FAIL down_steps got %b,%b want 11,01", seq[0], seq[1]); end
      end
      tests++; if (dir !== 1'b0) begin fails++; $display("FAIL down_dir got %b want 0", dir); end
      clear_log();
      target = 8'h82;
      cycles(30);
      tests++; if (seq.size() !== 0) begin fails++; $display("FAIL deadband_steps got %0d want 0", seq.size()); end
      tests++; if (busy_rises !== 0) begin fails++; $display("FAIL deadband_busy got %0d rises want 0", busy_rises); end
      tests++; if (dut.pos_q !== 8'h81) begin fails++; $display("FAIL deadband_pos got %h want 81", dut.pos_q); end
   endtask

   task automatic test_reversal();
      logic [1:0] exp [8] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
      int n = 0;
      clear_log();
      target = 8'h90;
      while (seq.size() < 3 && n < 100) begin cycles(1); n++; end
      tests++; if (seq.size() !== 3) begin fails++; $display("FAIL rev_timeout got %0d steps want 3", seq.size()); end
      target = 8'h7F;
      cycles(60);
      tests++; if (seq.size() !== 8) begin fails++; $display("FAIL rev_count got %0d want 8", seq.size()); end
      else begin
         for (int i = 0; i < 8; i++) begin
            tests++; if (seq[i] !== exp[i]) begin fails++; $display("FAIL rev_step%0d got %b want %b", i, seq[i], exp[i]); end
         end
      end
      tests++; if (dir !== 1'b0) begin fails++; $display("FAIL rev_dir got %b want 0", dir); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rev_busy got %b want 0", busy); end
      tests++; if (dut.pos_q !== 8'h7F) begin fails++; $display("FAIL rev_pos got %h want 7f", dut.pos_q); end
   endtask

   task automatic test_enable_gating();
      clear_log();
      enable = 1'b0;
      target = 8'hFF;
      cycles(100);
      tests++; if (seq.size() !== 0) begin fails++; $display("FAIL gate_steps got %0d want 0", seq.size()); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL gate_busy got %b want 0", busy); end
      tests++; if (steer !== 2'b10) begin fails++; $display("FAIL gate_steer got %b want 10", steer); end
      enable = 1'b1;
      cycles(30);
      tests++; if (seq.size() !== 0) begin fails++; $display("FAIL gate_sync_steps got %0d want 0", seq.size()); end
      tests++; if (busy_rises !== 0) begin fails++; $display("FAIL gate_sync_busy got %0d rises want 0", busy_rises); end
      tests++; if (dut.pos_q !== 8'hFF) begin fails++; $display("FAIL gate_sync_pos got %h want ff", dut.pos_q); end
   endtask

   task automatic test_reset_mid_move();
      enable = 1'b0;
      target = 8'h00;
      cycles(2);
      enable = 1'b1;
      cycles(5);
      clear_log();
      target = 8'hFF;
      cycles(20);
      tests++; if (busy !== 1'b1 || dir !== 1'b1) begin fails++; $display("FAIL rst_move_active got busy=%b dir=%b want 1,1", busy, dir); end
      reset = 1'b1;
      cycles(1);
      tests++; if (steer !== 2'b00) begin fails++; $display("FAIL rst_mid_steer got %b want 00", steer); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      tests++; if (dir !== 1'b0) begin fails++; $display("FAIL rst_mid_dir got %b want 0", dir); end
      reset = 1'b0;
      cycles(1);
      clear_log();
      cycles(30);
      tests++; if (seq.size() !== 0) begin fails++; $display("FAIL rst_resync_steps got %0d want 0", seq.size()); end
      tests++; if (busy_rises !== 0) begin fails++; $display("FAIL rst_resync_busy got %0d rises want 0", busy_rises); end
      tests++; if (dut.pos_q !== 8'hFF) begin fails++; $display("FAIL rst_resync_pos got %h want ff", dut.pos_q); end
   endtask

   initial begin
      test_reset();
      test_sync();
      test_move_up();
      test_move_down_deadband();
      test_reversal();
      test_enable_gating();
      test_reset_mid_move();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
